// File: rtl/sqrt_share_ctrl.sv
// Round-robin arbiter and sequencer for one shared iterative square-root engine.
// Each job runs load, WIDTH/2 radix-4 steps and a fix cycle, then a held response.
module sqrt_share_ctrl #(
   parameter int WIDTH   = 16,
   parameter int NUM_REQ = 4,
   localparam int ITER   = WIDTH / 2,
   localparam int IDW    = $clog2(NUM_REQ),
   localparam int ITW    = $clog2(ITER)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]   req_data,
   output logic                       eng_load,
   output logic [WIDTH-1:0]           eng_radicand,
   output logic                       eng_step,
   output logic [ITW-1:0]             eng_iter,
   output logic                       eng_fix,
   input  logic [WIDTH/2-1:0]         eng_root,
   input  logic [WIDTH/2:0]           eng_rem,
   output logic                       resp_valid,
   input  logic                       resp_ready,
   output logic [WIDTH/2-1:0]         resp_root,
   output logic [WIDTH/2:0]           resp_rem,
   output logic [IDW-1:0]             resp_id,
   output logic                       busy
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      STEP,
      FIX,
      RESP
   } state_t;

   localparam logic [ITW-1:0]   LAST_ITER = ITW'(ITER - 1);
   localparam logic [IDW-1:0]   LAST_REQ  = IDW'(NUM_REQ - 1);
   localparam logic [IDW:0]     NUM_REQ_W = (IDW + 1)'(NUM_REQ);
   localparam logic [NUM_REQ-1:0] ONE_REQ = {{(NUM_REQ - 1){1'b0}}, 1'b1};

   state_t             state;
   logic [IDW-1:0]     rr_ptr;
   logic [ITW-1:0]     cnt;
   logic [WIDTH/2:0]   rem_q;
   logic               rem_lat;

   logic [IDW:0]       rr_sum;
   logic [IDW-1:0]     rr_cand;
   logic [IDW-1:0]     grant_idx;
   logic               grant_any;
   logic [IDW-1:0]     rr_next;

   // Walk from the farthest candidate back to rr_ptr so the nearest valid requester wins.
   always_comb begin
      rr_sum    = '0;
      rr_cand   = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         rr_sum = {1'b0, rr_ptr} + (IDW + 1)'(j);
         if (rr_sum >= NUM_REQ_W) begin
            rr_sum = rr_sum - NUM_REQ_W;
         end
         rr_cand = rr_sum[IDW-1:0];
         if (req_valid[rr_cand]) begin
            grant_idx = rr_cand;
            grant_any = 1'b1;
         end
      end
   end

   assign rr_next   = (grant_idx == LAST_REQ) ? '0 : grant_idx + IDW'(1);
   assign req_ready = (state == IDLE && grant_any) ? (ONE_REQ << grant_idx) : '0;
   assign eng_iter  = cnt;
   assign busy      = (state != IDLE);

   // The engine's corrected remainder only appears in the first RESP cycle, so pass it
   // straight through then and hold the captured copy for any further stall cycles.
   assign resp_rem  = (state == RESP && !rem_lat) ? eng_rem : rem_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         cnt          <= '0;
         rem_q        <= '0;
         rem_lat      <= 1'b0;
         eng_load     <= 1'b0;
         eng_radicand <= '0;
         eng_step     <= 1'b0;
         eng_fix      <= 1'b0;
         resp_valid   <= 1'b0;
         resp_root    <= '0;
         resp_id      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  eng_radicand <= req_data[grant_idx*WIDTH +: WIDTH];
                  resp_id      <= grant_idx;
                  rr_ptr       <= rr_next;
                  eng_load     <= 1'b1;
                  state        <= LOAD;
               end
            end
            LOAD: begin
               eng_load     <= 1'b0;
               eng_radicand <= '0;
               eng_step     <= 1'b1;
               cnt          <= LAST_ITER;
               state        <= STEP;
            end
            STEP: begin
               if (cnt == '0) begin
                  eng_step <= 1'b0;
                  eng_fix  <= 1'b1;
                  state    <= FIX;
               end else begin
                  cnt <= cnt - ITW'(1);
               end
            end
            FIX: begin
               eng_fix    <= 1'b0;
               resp_root  <= eng_root;
               resp_valid <= 1'b1;
               rem_lat    <= 1'b0;
               state      <= RESP;
            end
            RESP: begin
               if (!rem_lat) begin
                  rem_q   <= eng_rem;
                  rem_lat <= 1'b1;
               end
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sqrt_share_ctrl.sv
// Directed bench for sqrt_share_ctrl with a behavioural non-restoring radix-4 sqrt engine.
module tb_sqrt_share_ctrl;

   localparam int WIDTH   = 16;
   localparam int NUM_REQ = 4;

   logic                      clk = 1'b0;
   logic                      reset = 1'b0;
   logic [NUM_REQ-1:0]        req_valid = '0;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*WIDTH-1:0]  req_data = '0;
   logic                      eng_load;
   logic [WIDTH-1:0]          eng_radicand;
   logic                      eng_step;
   logic [2:0]                eng_iter;
   logic                      eng_fix;
   logic [7:0]                eng_root;
   logic [8:0]                eng_rem;
   logic                      resp_valid;
   logic                      resp_ready = 1'b1;
   logic [7:0]                resp_root;
   logic [8:0]                resp_rem;
   logic [1:0]                resp_id;
   logic                      busy;

   int nApplied = 0;
   int nMiscompares = 0;
   int protoErr = 0;
   int iterLog[$];

   sqrt_share_ctrl #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
      .eng_load(eng_load), .eng_radicand(eng_radicand), .eng_step(eng_step),
      .eng_iter(eng_iter), .eng_fix(eng_fix), .eng_root(eng_root), .eng_rem(eng_rem),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_root(resp_root),
      .resp_rem(resp_rem), .resp_id(resp_id), .busy(busy)
   );

   always #5 clk = ~clk;

   // Behavioural engine: R signed partial remainder, Q partial root, D radicand.
   int mR, mQ, pairV, stepR, stepQ, fixR;
   logic [WIDTH-1:0] mD;

   always_comb begin
      pairV = int'(mD >> (2 * eng_iter)) & 3;
      if (mR >= 0) stepR = mR * 4 + pairV - (mQ * 4 + 1);
      else         stepR = mR * 4 + pairV + (mQ * 4 + 3);
      stepQ = mQ * 2 + ((stepR >= 0) ? 1 : 0);
      fixR  = (mR < 0) ? mR + mQ * 2 + 1 : mR;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mR <= 0;
         mQ <= 0;
         mD <= '0;
      end else if (eng_load) begin
         mR <= 0;
         mQ <= 0;
         mD <= eng_radicand;
      end else if (eng_step) begin
         mR <= stepR;
         mQ <= stepQ;
      end else if (eng_fix) begin
         mR <= fixR;
      end
   end

   assign eng_root = mQ[7:0];
   assign eng_rem  = mR[8:0];

   // Continuous protocol watch: one-hot grant, exclusive engine strobes, quiet engine when idle/responding.
   always @(negedge clk) begin
      if (eng_step) iterLog.push_back(int'(eng_iter));
      protoErr <= protoErr
                + (($countones(req_ready) > 1) ? 1 : 0)
                + ((int'(eng_load) + int'(eng_step) + int'(eng_fix) > 1) ? 1 : 0)
                + (((!busy || resp_valid) && (eng_load || eng_step || eng_fix)) ? 1 : 0);
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic [3:0]  mask;
      logic [63:0] data;
      int          expId;
      int          expRoot;
      int          expRem;
      int          hold;
   } vector_t;

   vector_t vecs[$];

   function automatic vector_t mkVec(logic [3:0] m, logic [15:0] d3, logic [15:0] d2,
                                     logic [15:0] d1, logic [15:0] d0,
                                     int id, int root, int rem, int hold);
      vector_t v;
      v.mask = m;
      v.data = {d3, d2, d1, d0};
      v.expId = id;
      v.expRoot = root;
      v.expRem = rem;
      v.hold = hold;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nApplied++;
      if (act !== exp) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vector_t v);
      logic [3:0] expReady;
      logic [7:0] r0;
      logic [8:0] m0;
      logic [1:0] i0;
      int n;
      int bad;
      bit seqOk;
      @(negedge clk);
      checkOutput("idle_before_job", {resp_valid, busy}, 0);
      req_valid  = v.mask;
      req_data   = v.data;
      resp_ready = (v.hold == 0);
      n = 0;
      #1;
      while (req_ready == '0 && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      expReady = 4'b0001 << v.expId;
      checkOutput("req_ready_grant", req_ready, expReady);
      if (req_ready == '0) return;
      @(posedge clk);
      iterLog.delete();
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!resp_valid && n < 40);
      checkOutput("latency", n, 11);
      checkOutput("resp_root", resp_root, v.expRoot);
      checkOutput("resp_rem", resp_rem, v.expRem);
      checkOutput("resp_id", resp_id, v.expId);
      seqOk = (iterLog.size() == 8);
      for (int k = 0; k < iterLog.size() && k < 8; k++) begin
         if (iterLog[k] != 7 - k) seqOk = 1'b0;
      end
      checkOutput("eng_iter_sequence", seqOk, 1);
      if (v.hold > 0) begin
         r0 = resp_root;
         m0 = resp_rem;
         i0 = resp_id;
         req_valid = 4'hF;
         bad = 0;
         repeat (v.hold) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_root !== r0 || resp_rem !== m0 ||
                resp_id !== i0 || req_ready !== 4'b0 || busy !== 1'b1) bad++;
         end
         checkOutput("hold_stable", bad, 0);
         resp_ready = 1'b1;
         @(negedge clk);
         checkOutput("hold_release_idle", {resp_valid, busy}, 0);
         req_valid = '0;
      end
   endtask

   initial begin
      int n;
      int bad;
      vector_t post;
      int roots[4] = '{12, 255, 0, 31};
      int rems[4]  = '{0, 510, 0, 39};

      #1;
      checkOutput("reset_state",
                  {req_ready, eng_load, eng_radicand, eng_step, eng_iter, eng_fix,
                   resp_valid, resp_root, resp_rem, resp_id, busy}, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("after_release", {resp_valid, busy, eng_load, eng_step, eng_fix}, 0);

      vecs.push_back(mkVec(4'b0001, 0, 0, 0, 144, 0, 12, 0, 0));
      vecs.push_back(mkVec(4'b0010, 0, 0, 65535, 0, 1, 255, 510, 0));
      vecs.push_back(mkVec(4'b0100, 0, 0, 0, 0, 2, 0, 0, 0));
      vecs.push_back(mkVec(4'b1000, 1000, 0, 0, 0, 3, 31, 39, 0));
      for (int i = 0; i < 8; i++) begin
         vecs.push_back(mkVec(4'b1111, 1000, 0, 65535, 144, i % 4, roots[i % 4], rems[i % 4], 0));
      end
      vecs.push_back(mkVec(4'b1000, 12345, 0, 0, 0, 3, 111, 24, 0));
      vecs.push_back(mkVec(4'b0100, 0, 15, 0, 0, 2, 3, 6, 0));
      vecs.push_back(mkVec(4'b1111, 16, 2, 1, 1, 3, 4, 0, 0));
      vecs.push_back(mkVec(4'b0110, 0, 2, 1, 0, 1, 1, 0, 0));

      foreach (vecs[i]) applyStimulus(vecs[i]);

      $display("[TB] stalled response sequence");
      applyStimulus(mkVec(4'b0110, 0, 1000, 0, 0, 2, 31, 39, 20));

      $display("[TB] reset during STEP sequence");
      @(negedge clk);
      req_valid  = 4'b0001;
      req_data   = {16'd0, 16'd0, 16'd0, 16'd65535};
      resp_ready = 1'b1;
      n = 0;
      while (!(eng_step && eng_iter == 3'd4) && n < 30) begin
         @(negedge clk);
         n++;
      end
      checkOutput("reach_iter4", {eng_step, eng_iter}, {1'b1, 3'd4});
      reset = 1'b0;
      req_valid = '0;
      #1;
      checkOutput("reset_mid_job",
                  {req_ready, eng_load, eng_radicand, eng_step, eng_iter, eng_fix,
                   resp_valid, resp_root, resp_rem, resp_id, busy}, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      bad = 0;
      repeat (15) begin
         @(negedge clk);
         if (resp_valid || busy) bad++;
      end
      checkOutput("no_resp_after_reset", bad, 0);
      post = mkVec(4'b1111, 7, 7, 7, 999, 0, 31, 38, 0);
      applyStimulus(post);

      @(negedge clk);
      req_valid = '0;
      repeat (3) @(negedge clk);
      checkOutput("protocol_watch", protoErr, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompares);
      $finish;
   end

endmodule
